sensor_frame_writer: RTL and testbench



---
 rtl/sensor_frame_writer_pkg.sv | 22 ++
 rtl/sensor_frame_writer.sv | 155 +++++++++++++++
 tb/tb_sensor_frame_writer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sensor_frame_writer_pkg.sv
// -----------------------------------------------------------------------------
// sensor_frame_writer_pkg
// Constants and types shared by the frame writer and the detector side that
// parses the byte stream.
//   fw_state_e         : frame writer FSM states
//   FW_SYNC_BYTE       : default first byte of every frame
//   FW_FRAME_OVERHEAD  : bytes per frame besides the sample (sync, seq, csum)
// -----------------------------------------------------------------------------
package sensor_frame_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_SEQ  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } fw_state_e;

    localparam logic [7:0] FW_SYNC_BYTE      = 8'hA5;
    localparam int         FW_FRAME_OVERHEAD = 3;

endpackage

// File: rtl/sensor_frame_writer.sv
// -----------------------------------------------------------------------------
// sensor_frame_writer
// Takes one SAMPLE_W-bit sample through a valid/ready handshake and writes it
// as a framed byte sequence into a byte FIFO:
//   SYNC_BYTE, seq, sample bytes MSB first, csum (XOR of seq and sample bytes)
//
// Handshake: a sample transfers on a rising edge where sample_valid and
// sample_ready are both 1. sample_ready is 1 only while IDLE; the source must
// hold sample_data stable while sample_valid is 1 and sample_ready is 0.
// On the FIFO side a byte transfers on every edge where fifo_wr_en is 1;
// fifo_wr_en is ~fifo_full in every frame state, and the presented byte does
// not change until it has been written.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   sample_data       sample to frame
//   sample_valid      sample_data is valid
//   sample_ready      block can accept a sample this cycle
//   fifo_full         downstream FIFO cannot accept a write
//   fifo_wr_en        FIFO write strobe
//   fifo_wr_data      byte to write
//   frame_count       completed frames, wraps 65535 -> 0
//   dbg_state_o       current FSM state, for observation only
// -----------------------------------------------------------------------------
module sensor_frame_writer
    import sensor_frame_writer_pkg::*;
#(
    parameter int         SAMPLE_W  = 16,
    parameter logic [7:0] SYNC_BYTE = FW_SYNC_BYTE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                fifo_full,
    output logic                fifo_wr_en,
    output logic [7:0]          fifo_wr_data,
    output logic [15:0]         frame_count,
    output fw_state_e           dbg_state_o
);

    localparam int NB    = SAMPLE_W / 8;
    // Keep the index at least one bit wide so NB = 1 still elaborates.
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    fw_state_e           state_q, state_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic [7:0]          seq_q, seq_d;
    logic [7:0]          csum_q, csum_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [15:0]         frame_count_q, frame_count_d;

    logic [IDX_W-1:0]    byte_sel;
    logic [7:0]          data_byte;
    logic                last_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            sample_q      <= '0;
            seq_q         <= '0;
            csum_q        <= '0;
            idx_q         <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            sample_q      <= sample_d;
            seq_q         <= seq_d;
            csum_q        <= csum_d;
            idx_q         <= idx_d;
            frame_count_q <= frame_count_d;
        end
    end

    // idx counts bytes already sent; the byte on the wire is NB-1-idx so the
    // most significant byte leaves first.
    assign byte_sel  = IDX_W'(NB - 1) - idx_q;
    assign last_byte = (idx_q == IDX_W'(NB - 1));

    always_comb begin
        data_byte = '0;
        for (int b = 0; b < NB; b++) begin
            if (byte_sel == IDX_W'(b)) begin
                data_byte = sample_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        sample_d      = sample_q;
        seq_d         = seq_q;
        csum_d        = csum_q;
        idx_d         = idx_q;
        frame_count_d = frame_count_q;
        sample_ready  = 1'b0;
        fifo_wr_en    = 1'b0;
        fifo_wr_data  = 8'h00;

        case (state_q)
            ST_IDLE: begin
                sample_ready = 1'b1;
                if (sample_valid) begin
                    sample_d = sample_data;
                    csum_d   = 8'h00;
                    idx_d    = '0;
                    state_d  = ST_SYNC;
                end
            end
            ST_SYNC: begin
                fifo_wr_en   = ~fifo_full;
                fifo_wr_data = SYNC_BYTE;
                if (!fifo_full) begin
                    state_d = ST_SEQ;
                end
            end
            ST_SEQ: begin
                fifo_wr_en   = ~fifo_full;
                fifo_wr_data = seq_q;
                if (!fifo_full) begin
                    csum_d  = csum_q ^ seq_q;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                fifo_wr_en   = ~fifo_full;
                fifo_wr_data = data_byte;
                if (!fifo_full) begin
                    csum_d = csum_q ^ data_byte;
                    idx_d  = idx_q + 1'b1;
                    if (last_byte) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                fifo_wr_en   = ~fifo_full;
                fifo_wr_data = csum_q;
                if (!fifo_full) begin
                    seq_d         = seq_q + 8'd1;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign frame_count = frame_count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sensor_frame_writer.sv
module tb_sensor_frame_writer;
    import sensor_frame_writer_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic [15:0] frame_count;
    fw_state_e   dbg_state_o;

    int pass_cnt  = 0;
    int check_cnt = 0;

    sensor_frame_writer #(.SAMPLE_W(16), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .frame_count  (frame_count),
        .dbg_state_o  (dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame with no backpressure. Entered and left at a negedge in IDLE.
    task automatic run_frame(input logic [15:0] d, input logic [7:0] exp_seq,
                             input logic [7:0] exp_csum, input logic [15:0] exp_fc);
        logic [7:0] exp_b [5];
        exp_b[0] = 8'hA5;
        exp_b[1] = exp_seq;
        exp_b[2] = d[15:8];
        exp_b[3] = d[7:0];
        exp_b[4] = exp_csum;
        @(posedge clk); #1;
        sample_valid = 1'b1;
        sample_data  = d;
        @(negedge clk);
        check("idle_ready", {31'd0, sample_ready}, 32'd1);
        check("idle_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("frame_wr_en", {31'd0, fifo_wr_en}, 32'd1);
            check("frame_byte", {24'd0, fifo_wr_data}, {24'd0, exp_b[i]});
            check("frame_busy", {31'd0, sample_ready}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("frame_count", {16'd0, frame_count}, {16'd0, exp_fc});
        check("ready_after", {31'd0, sample_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0]  exp_en   [12];
        logic [7:0]  exp_byte [12];
        logic [7:0]  exp_rdy  [12];
        logic [15:0] d;
        logic [7:0]  s;

        reset        = 1'b0;
        sample_data  = 16'h0000;
        sample_valid = 1'b0;
        fifo_full    = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        check("rst_wr_data", {24'd0, fifo_wr_data}, 32'd0);
        check("rst_frame_count", {16'd0, frame_count}, 32'd0);
        check("rst_state", {29'd0, dbg_state_o}, {29'd0, ST_IDLE});
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_ready", {31'd0, sample_ready}, 32'd1);

        // basic frame and second frame
        run_frame(16'h1234, 8'h00, 8'h26, 16'd1);
        run_frame(16'hFFFF, 8'h01, 8'h01, 16'd2);

        // backpressure: three stalled cycles on the first data byte
        @(posedge clk); #1;
        sample_valid = 1'b1;
        sample_data  = 16'h1234;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        @(negedge clk);
        check("bp_sync", {24'd0, fifo_wr_data}, 32'hA5);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_seq", {24'd0, fifo_wr_data}, 32'h02);
        @(posedge clk); #1;
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stall_en", {31'd0, fifo_wr_en}, 32'd0);
            check("bp_stall_byte", {24'd0, fifo_wr_data}, 32'h12);
            @(posedge clk); #1;
        end
        fifo_full = 1'b0;
        @(negedge clk);
        check("bp_resume_en", {31'd0, fifo_wr_en}, 32'd1);
        check("bp_resume_byte", {24'd0, fifo_wr_data}, 32'h12);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_byte_lo", {24'd0, fifo_wr_data}, 32'h34);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_csum", {24'd0, fifo_wr_data}, 32'h24);
        check("bp_csum_en", {31'd0, fifo_wr_en}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_frame_count", {16'd0, frame_count}, 32'd3);
        check("bp_ready", {31'd0, sample_ready}, 32'd1);

        // back-to-back: valid held high across two samples
        exp_rdy  = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        exp_en   = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        exp_byte = '{8'h00, 8'hA5, 8'h03, 8'hAB, 8'hCD, 8'h65,
                     8'h00, 8'hA5, 8'h04, 8'h5A, 8'h0F, 8'h51};
        sample_valid = 1'b1;
        sample_data  = 16'hABCD;
        for (int i = 0; i < 12; i++) begin
            check("b2b_ready", {31'd0, sample_ready}, {24'd0, exp_rdy[i]});
            check("b2b_wr_en", {31'd0, fifo_wr_en}, {24'd0, exp_en[i]});
            check("b2b_byte", {24'd0, fifo_wr_data}, {24'd0, exp_byte[i]});
            @(posedge clk); #1;
            if (i == 0) sample_data = 16'h5A0F;
            if (i == 6) sample_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_frame_count", {16'd0, frame_count}, 32'd5);
        check("b2b_ready_end", {31'd0, sample_ready}, 32'd1);

        // reset asserted in the DATA state
        @(posedge clk); #1;
        sample_valid = 1'b1;
        sample_data  = 16'h7788;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("mid_data_state", {29'd0, dbg_state_o}, {29'd0, ST_DATA});
        check("mid_data_en", {31'd0, fifo_wr_en}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_en", {31'd0, fifo_wr_en}, 32'd0);
        check("mid_rst_count", {16'd0, frame_count}, 32'd0);
        @(posedge clk); #1;
        check("mid_rst_hold_en", {31'd0, fifo_wr_en}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_frame(16'h1234, 8'h00, 8'h26, 16'd1);

        // sequence wrap: frames 2..257 with random samples
        for (int k = 2; k <= 257; k++) begin
            d = 16'($urandom_range(0, 65535));
            s = 8'((k - 1) % 256);
            run_frame(d, s, s ^ d[15:8] ^ d[7:0], 16'(k));
        end
        check("wrap_frame_count", {16'd0, frame_count}, 32'd257);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
